// File: rtl/sample_window_counter_if.sv
// Bus bundle for sample_window_counter.
// Signals:
//   clear, start, cnt_up, window_len, mode_oneshot      controller -> counter
//   count_out, window_done, windows_completed, busy,
//   cfg_err                                             counter -> controller
// Modports: master drives the controls and reads the status (the controller side);
// slave is the counter itself.
interface sample_window_counter_if #(
  parameter int CNT_WIDTH = 10,
  parameter int WIN_WIDTH = 8
);
  logic                 clear;
  logic                 start;
  logic                 cnt_up;
  logic [CNT_WIDTH-1:0] window_len;
  logic                 mode_oneshot;
  logic [CNT_WIDTH-1:0] count_out;
  logic                 window_done;
  logic [WIN_WIDTH-1:0] windows_completed;
  logic                 busy;
  logic                 cfg_err;

  modport master (
    output clear, start, cnt_up, window_len, mode_oneshot,
    input  count_out, window_done, windows_completed, busy, cfg_err
  );

  modport slave (
    input  clear, start, cnt_up, window_len, mode_oneshot,
    output count_out, window_done, windows_completed, busy, cfg_err
  );
endinterface

// File: rtl/sample_window_counter.sv
// Programmable sample-window counter.
// Counts cnt_up strobes into windows of a run-time length latched at start,
// pulses window_done at the end of each window and keeps a saturating tally
// of completed windows. One-shot mode stops after a single window; continuous
// mode runs windows back to back.
// Ports:
//   clk    rising-edge clock
//   n_rst  asynchronous active-low reset
//   bus    sample_window_counter_if.slave (controls in, registered status out)
module sample_window_counter #(
  parameter int CNT_WIDTH = 10,
  parameter int WIN_WIDTH = 8
) (
  input logic                    clk,
  input logic                    n_rst,
  sample_window_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic                 mode_q, mode_d;
  logic                 done_q, done_d;
  logic [WIN_WIDTH-1:0] wins_q, wins_d;
  logic                 busy_q;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] next_cnt;

  // Tally increment that sticks at all-ones instead of wrapping.
  function automatic logic [WIN_WIDTH-1:0] sat_inc(input logic [WIN_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Priority: clear > start > cnt_up.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    len_d    = len_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    wins_d   = wins_q;
    err_d    = err_q;
    next_cnt = count_q;
    if (bus.clear) begin
      state_d = IDLE;
      count_d = '0;
      wins_d  = '0;
      err_d   = 1'b0;
    end else if (bus.start) begin
      if (bus.window_len == '0) begin
        // A zero-length window is meaningless: flag it, leave everything else.
        err_d = 1'b1;
      end else begin
        len_d   = bus.window_len;
        mode_d  = bus.mode_oneshot;
        count_d = '0;
        state_d = COUNT;
        err_d   = 1'b0;
      end
    end else if (state_q == COUNT && bus.cnt_up) begin
      // A full window rolls over to the first sample of the next one.
      next_cnt = (count_q == len_q) ? CNT_WIDTH'(1) : count_q + 1'b1;
      count_d  = next_cnt;
      if (next_cnt == len_q) begin
        done_d = 1'b1;
        wins_d = sat_inc(wins_q);
        if (mode_q) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      wins_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      wins_q  <= wins_d;
      // busy is registered from the next state so it tracks state_q exactly.
      busy_q  <= (state_d == COUNT);
      err_q   <= err_d;
    end
  end

  assign bus.count_out         = count_q;
  assign bus.window_done       = done_q;
  assign bus.windows_completed = wins_q;
  assign bus.busy              = busy_q;
  assign bus.cfg_err           = err_q;

endmodule

// File: tb/tb_sample_window_counter.sv
// Directed bench for sample_window_counter (CNT_WIDTH=10, WIN_WIDTH=2 so the
// completed-window tally saturates quickly).
module tb_sample_window_counter;

  localparam int CW = 10;
  localparam int WW = 2;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;

  sample_window_counter_if #(.CNT_WIDTH(CW), .WIN_WIDTH(WW)) swc_if ();

  sample_window_counter #(.CNT_WIDTH(CW), .WIN_WIDTH(WW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (swc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic clr, input logic st, input logic up,
                       input logic [CW-1:0] len, input logic os);
    swc_if.clear        = clr;
    swc_if.start        = st;
    swc_if.cnt_up       = up;
    swc_if.window_len   = len;
    swc_if.mode_oneshot = os;
  endtask

  task automatic check_all(input string tag, input int cnt, input int done,
                           input int wins, input int busy, input int err);
    check_eq({tag, ".count"}, 32'(swc_if.count_out), cnt);
    check_eq({tag, ".done"},  32'(swc_if.window_done), done);
    check_eq({tag, ".wins"},  32'(swc_if.windows_completed), wins);
    check_eq({tag, ".busy"},  32'(swc_if.busy), busy);
    check_eq({tag, ".err"},   32'(swc_if.cfg_err), err);
  endtask

  int exp_cnt2[9]  = '{1, 2, 3, 4, 1, 2, 3, 4, 1};
  int exp_done2[9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
  int exp_wins2[9] = '{0, 0, 0, 1, 1, 1, 1, 2, 2};
  int exp_cnt3[5]  = '{1, 2, 3, 3, 3};
  int exp_done3[5] = '{0, 0, 1, 0, 0};
  int exp_busy3[5] = '{1, 1, 0, 0, 0};
  int exp_wins5[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    checks   = 0;
    failures = 0;
    n_rst    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    #22;
    check_all("reset", 0, 0, 0, 0, 0);
    n_rst = 1'b1;

    // Reset in the middle of a window.
    drive(1'b0, 1'b1, 1'b0, CW'(8), 1'b0);
    tick();
    check_all("t1.start", 0, 0, 0, 1, 0);
    drive(1'b0, 1'b0, 1'b1, CW'(8), 1'b0);
    repeat (5) tick();
    check_eq("t1.count5", 32'(swc_if.count_out), 5);
    #2;
    n_rst = 1'b0;
    #1;
    check_all("t1.async_rst", 0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    #3;
    n_rst = 1'b1;

    // len=4 continuous, 9 strobes.
    drive(1'b0, 1'b1, 1'b1, CW'(4), 1'b0);
    tick();
    check_all("t2.start", 0, 0, 0, 1, 0);
    drive(1'b0, 1'b0, 1'b1, CW'(4), 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check_eq($sformatf("t2.count[%0d]", i), 32'(swc_if.count_out), exp_cnt2[i]);
      check_eq($sformatf("t2.done[%0d]", i), 32'(swc_if.window_done), exp_done2[i]);
      check_eq($sformatf("t2.wins[%0d]", i), 32'(swc_if.windows_completed), exp_wins2[i]);
    end
    drive(1'b0, 1'b0, 1'b0, CW'(4), 1'b0);
    tick();
    check_all("t2.idle_strobe", 1, 0, 2, 1, 0);

    // len=3 one-shot, 5 strobes.
    drive(1'b0, 1'b1, 1'b0, CW'(3), 1'b1);
    tick();
    check_all("t3.start", 0, 0, 2, 1, 0);
    drive(1'b0, 1'b0, 1'b1, CW'(0), 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("t3.count[%0d]", i), 32'(swc_if.count_out), exp_cnt3[i]);
      check_eq($sformatf("t3.done[%0d]", i), 32'(swc_if.window_done), exp_done3[i]);
      check_eq($sformatf("t3.busy[%0d]", i), 32'(swc_if.busy), exp_busy3[i]);
    end
    check_eq("t3.wins", 32'(swc_if.windows_completed), 3);

    // Zero-length start is rejected, next valid start clears the flag.
    drive(1'b0, 1'b1, 1'b1, CW'(0), 1'b0);
    tick();
    check_all("t4.bad_start", 3, 0, 3, 0, 1);
    drive(1'b0, 1'b0, 1'b0, CW'(0), 1'b0);
    tick();
    check_eq("t4.err_sticky", 32'(swc_if.cfg_err), 1);
    drive(1'b0, 1'b1, 1'b0, CW'(2), 1'b0);
    tick();
    check_all("t4.good_start", 0, 0, 3, 1, 0);

    // clear + start + cnt_up together in the middle of a window.
    drive(1'b0, 1'b0, 1'b1, CW'(2), 1'b0);
    tick();
    check_eq("t6.mid", 32'(swc_if.count_out), 1);
    drive(1'b1, 1'b1, 1'b1, CW'(5), 1'b0);
    tick();
    check_all("t6.clear", 0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, CW'(5), 1'b0);
    tick();
    check_all("t6.idle_ignore", 0, 0, 0, 0, 0);

    // len=1 continuous: every strobe closes a window, tally saturates at 3.
    drive(1'b0, 1'b1, 1'b0, CW'(1), 1'b0);
    tick();
    check_all("t5.start", 0, 0, 0, 1, 0);
    drive(1'b0, 1'b0, 1'b1, CW'(1), 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("t5.count[%0d]", i), 32'(swc_if.count_out), 1);
      check_eq($sformatf("t5.done[%0d]", i), 32'(swc_if.window_done), 1);
      check_eq($sformatf("t5.wins[%0d]", i), 32'(swc_if.windows_completed), exp_wins5[i]);
    end
    drive(1'b0, 1'b0, 1'b0, CW'(1), 1'b0);
    tick();
    check_all("t5.hold", 1, 0, 3, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
